// File: rtl/alu_control_unit_if.sv
// Bus interface for the ALU control decoder.
//   aluop   [1:0] ALUOp from main control (00 mem, 01 branch, 10 R-type, 11 reserved)
//   funct   [5:0] instruction bits [5:0], meaningful only for R-type
//   select  [2:0] registered ALU operation select
//   illegal       registered flag: R-type with an unsupported funct code
// master drives aluop/funct (control side); slave is the decoder.
interface alu_control_unit_if;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic [2:0] select;
  logic       illegal;

  modport master (
    output aluop,
    output funct,
    input  select,
    input  illegal
  );

  modport slave (
    input  aluop,
    input  funct,
    output select,
    output illegal
  );
endinterface

// File: rtl/alu_control_unit.sv
// ALU control decoder: maps ALUOp and the R-type funct field to the 3-bit ALU
// operation select. Outputs are registered, so the decode of the inputs seen
// at one rising edge is visible right after that edge.
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset (select = add, illegal = 0)
//   bus   alu_control_unit_if.slave: aluop, funct in; select, illegal out
module alu_control_unit (
  input logic               clk,
  input logic               rst,
  alu_control_unit_if.slave bus
);

  localparam logic [2:0] SelAnd = 3'b000;
  localparam logic [2:0] SelOr  = 3'b001;
  localparam logic [2:0] SelAdd = 3'b010;
  localparam logic [2:0] SelSub = 3'b110;
  localparam logic [2:0] SelSlt = 3'b111;

  logic [2:0] select_d, select_q;
  logic       illegal_d, illegal_q;

  always_comb begin
    select_d  = SelAdd;
    illegal_d = 1'b0;
    unique case (bus.aluop)
      2'b00: select_d = SelAdd;
      2'b01: select_d = SelSub;
      2'b10: begin
        unique case (bus.funct)
          6'b100000: select_d = SelAdd;
          6'b100010: select_d = SelSub;
          6'b100100: select_d = SelAnd;
          6'b100101: select_d = SelOr;
          6'b101010: select_d = SelSlt;
          default: begin
            select_d  = SelAdd;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Reserved encoding falls back to add without raising the debug flag.
      default: select_d = SelAdd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      select_q  <= SelAdd;
      illegal_q <= 1'b0;
    end else begin
      select_q  <= select_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.select  = select_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;

  logic clk;
  logic rst;
  alu_control_unit_if bus ();

  alu_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table of supported R-type functions and their selects.
  typedef struct {
    logic [5:0] funct;
    logic [2:0] sel;
  } entry_t;
  entry_t rtab [5] = '{
    '{6'h20, 3'd2}, '{6'h22, 3'd6}, '{6'h24, 3'd0}, '{6'h25, 3'd1}, '{6'h2a, 3'd7}
  };

  logic [2:0] exp_sel;
  logic       exp_ill;
  bit         model_valid = 0;

  always @(posedge clk) begin
    logic [2:0] s;
    logic       il;
    bit         found;
    s  = 3'd2;
    il = 1'b0;
    if (!rst) begin
      if (bus.aluop == 2'd1) s = 3'd6;
      else if (bus.aluop == 2'd2) begin
        found = 0;
        foreach (rtab[i]) if (rtab[i].funct == bus.funct) begin
          s = rtab[i].sel;
          found = 1;
        end
        il = !found;
      end
    end
    exp_sel = s;
    exp_ill = il;
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_select", bus.select, exp_sel);
      check("model_illegal", {2'b0, bus.illegal}, {2'b0, exp_ill});
    end
  end

  // Drive inputs, let one rising edge pass, then sample 1 time unit later.
  task automatic apply(input logic r, input logic [1:0] op, input logic [5:0] fn);
    rst       = r;
    bus.aluop = op;
    bus.funct = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] sel, input logic ill);
    check({name, "_select"}, bus.select, sel);
    check({name, "_illegal"}, {2'b0, bus.illegal}, {2'b0, ill});
  endtask

  initial begin
    rst       = 1'b1;
    bus.aluop = 2'b10;
    bus.funct = 6'b101010;
    @(posedge clk);
    #1;

    apply(1'b1, 2'b10, 6'b101010); expect_out("reset", 3'b010, 1'b0);
    apply(1'b0, 2'b10, 6'b101010); expect_out("post_reset_slt", 3'b111, 1'b0);

    apply(1'b0, 2'b00, 6'b100000); expect_out("mem_add", 3'b010, 1'b0);
    apply(1'b0, 2'b01, 6'b100000); expect_out("beq_sub", 3'b110, 1'b0);

    apply(1'b0, 2'b10, 6'b100000); expect_out("r_add", 3'b010, 1'b0);
    apply(1'b0, 2'b10, 6'b100010); expect_out("r_sub", 3'b110, 1'b0);
    apply(1'b0, 2'b10, 6'b100100); expect_out("r_and", 3'b000, 1'b0);
    apply(1'b0, 2'b10, 6'b100101); expect_out("r_or", 3'b001, 1'b0);
    apply(1'b0, 2'b10, 6'b101010); expect_out("r_slt", 3'b111, 1'b0);

    apply(1'b0, 2'b10, 6'b000000); expect_out("illegal_zero", 3'b010, 1'b1);
    apply(1'b0, 2'b10, 6'b100100); expect_out("after_illegal_and", 3'b000, 1'b0);
    apply(1'b0, 2'b10, 6'b111111); expect_out("illegal_ones", 3'b010, 1'b1);
    apply(1'b0, 2'b11, 6'b100010); expect_out("reserved", 3'b010, 1'b0);
    apply(1'b0, 2'b01, 6'b000000); expect_out("beq_any_funct", 3'b110, 1'b0);

    // Mid-cycle input change must not reach the outputs before the next edge.
    apply(1'b0, 2'b10, 6'b100101); expect_out("hold_before", 3'b001, 1'b0);
    bus.aluop = 2'b10;
    bus.funct = 6'b101010;
    #2;
    expect_out("hold_mid", 3'b001, 1'b0);
    @(posedge clk);
    #1;
    expect_out("hold_after", 3'b111, 1'b0);

    // Reset overrides a pending illegal decode.
    apply(1'b1, 2'b10, 6'b000001); expect_out("reset_over_illegal", 3'b010, 1'b0);
    apply(1'b0, 2'b10, 6'b100010); expect_out("resume_sub", 3'b110, 1'b0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
